lr_deshift_sfr: RTL and testbench



---
 rtl/lr_sfr_pkg.sv | 34 +++
 rtl/lr_deshift_sfr_if.sv | 46 ++++
 rtl/sfr_bit_counter.sv | 38 +++
 rtl/lr_deshift_sfr.sv | 139 +++++++++++++
 tb/tb_lr_deshift_sfr.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lr_sfr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lr_sfr_pkg
// Description : Types and helpers shared by the left/right shift SFR family
//               (transmit-side shifter and receive-side deshifter).
// Options     : DESHIFT_PARITY_EN (PAR state is used only when defined)
// Revision    : 1.0 - initial release
// ============================================================================
package lr_sfr_pkg;

  // Word-assembly progress of a deshifter
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAR  = 2'd2,
    HOLD = 2'd3
  } sfr_state_e;

  // Direction latched on the first bit of a word
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } sfr_dir_e;

  // Bit-counter width able to hold the value SIZE itself
  function automatic int cw_of(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int C_DEFAULT_SIZE = 32;
  localparam int C_DEFAULT_CW   = cw_of(C_DEFAULT_SIZE);

endpackage
`default_nettype wire

// File: rtl/lr_deshift_sfr_if.sv
`default_nettype none
// ============================================================================
// Module      : lr_deshift_sfr_if
// Description : Serial-input and parallel-output handshake bundle of the
//               deshift SFR. The slave modport is the SFR, master the peer.
// Options     : DESHIFT_PARITY_EN adds parity_err
// Revision    : 1.0 - initial release
// ============================================================================
interface lr_deshift_sfr_if
  import lr_sfr_pkg::*;
#(
  parameter int SIZE = 32
) ();
  localparam int CW = cw_of(SIZE);

  logic            sin;
  logic            sin_valid;
  logic            sin_ready;
  logic            left;
  logic            right;
  logic [SIZE-1:0] Q;
  logic [CW-1:0]   cnt;
  logic            out_valid;
  logic            out_ready;
`ifdef DESHIFT_PARITY_EN
  logic            parity_err;
`endif

  modport slave (
    input  sin, sin_valid, left, right, out_ready,
`ifdef DESHIFT_PARITY_EN
    output parity_err,
`endif
    output sin_ready, Q, cnt, out_valid
  );

  modport master (
    output sin, sin_valid, left, right, out_ready,
`ifdef DESHIFT_PARITY_EN
    input  parity_err,
`endif
    input  sin_ready, Q, cnt, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/sfr_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : sfr_bit_counter
// Description : Bit counter for the SFR family. Synchronous clear wins over
//               enable; term flags the increment that brings cnt to SIZE.
// Revision    : 1.0 - initial release
// ============================================================================
module sfr_bit_counter #(
  parameter int SIZE = 32,
  parameter int CW   = $clog2(SIZE + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clr,
  input  wire logic          en,
  output logic [CW-1:0]      cnt,
  output logic               term
);
  localparam logic [CW-1:0] c_last = CW'(SIZE - 1);

  logic [CW-1:0] r_cnt;

  assign cnt  = r_cnt;
  assign term = en && !clr && (r_cnt == c_last);

  // Count accepted bits; clear takes priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lr_deshift_sfr.sv
`default_nettype none
// ============================================================================
// Module      : lr_deshift_sfr
// Description : Serial-in, parallel-out SFR. Shifts bits in MSB-first (left)
//               or LSB-first (right) and offers the SIZE-bit word through a
//               valid/ready handshake.
// Options     : DESHIFT_PARITY_EN - take one even-parity bit after the data
//               bits and report parity_err alongside the word
// Revision    : 1.0 - initial release
// ============================================================================
module lr_deshift_sfr
  import lr_sfr_pkg::*;
#(
  parameter  int SIZE = 32,
  localparam int CW   = cw_of(SIZE)
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       clr,
  lr_deshift_sfr_if.slave bus
);
  sfr_state_e      r_state;
  sfr_dir_e        r_dir;
  logic [SIZE-1:0] r_q;
  logic            r_out_valid;
  logic            w_sin_ready;
  logic            w_accept;
  logic            w_count_en;
  logic            w_drain;
  logic            w_term;
  logic [CW-1:0]   w_cnt;
`ifdef DESHIFT_PARITY_EN
  logic            r_par_err;
`endif

  // Ready only when a direction is known (IDLE) or a word is in progress
  always_comb begin
    w_sin_ready = 1'b0;
    case (r_state)
      IDLE:    w_sin_ready = bus.left || bus.right;
      FILL:    w_sin_ready = 1'b1;
`ifdef DESHIFT_PARITY_EN
      PAR:     w_sin_ready = 1'b1;
`endif
      default: w_sin_ready = 1'b0;
    endcase
  end

  assign w_accept   = bus.sin_valid && w_sin_ready;
  assign w_count_en = w_accept && ((r_state == IDLE) || (r_state == FILL));
  assign w_drain    = (r_state == HOLD) && bus.out_ready;

  sfr_bit_counter #(
    .SIZE (SIZE),
    .CW   (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr || w_drain),
    .en    (w_count_en),
    .cnt   (w_cnt),
    .term  (w_term)
  );

  // Word-assembly FSM: shift register, direction latch and output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dir       <= DIR_LEFT;
      r_q         <= '0;
      r_out_valid <= 1'b0;
`ifdef DESHIFT_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else if (clr) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_out_valid <= 1'b0;
`ifdef DESHIFT_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // First bit starts from zero so stale word content never leaks in
            r_dir   <= bus.left ? DIR_LEFT : DIR_RIGHT;
            r_q     <= bus.left ? {{(SIZE-1){1'b0}}, bus.sin}
                                : {bus.sin, {(SIZE-1){1'b0}}};
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_q <= (r_dir == DIR_LEFT) ? {r_q[SIZE-2:0], bus.sin}
                                       : {bus.sin, r_q[SIZE-1:1]};
            if (w_term) begin
`ifdef DESHIFT_PARITY_EN
              r_state     <= PAR;
`else
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef DESHIFT_PARITY_EN
        PAR: begin
          if (w_accept) begin
            r_par_err   <= (^r_q) ^ bus.sin;
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
`endif
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
`ifdef DESHIFT_PARITY_EN
            r_par_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sin_ready  = w_sin_ready;
  assign bus.Q          = r_q;
  assign bus.cnt        = w_cnt;
  assign bus.out_valid  = r_out_valid;
`ifdef DESHIFT_PARITY_EN
  assign bus.parity_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lr_deshift_sfr.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr_deshift_sfr
// Description : Scoreboard bench for lr_deshift_sfr (SIZE=8). A high-level
//               model collects accepted bits, builds the expected word and
//               queues it; a monitor compares whenever out_valid is seen.
// Options     : DESHIFT_PARITY_EN - parity bit and parity_err are modelled
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lr_deshift_sfr;
  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] word;
    logic            perr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;

  lr_deshift_sfr_if #(.SIZE(SIZE)) bus ();

  lr_deshift_sfr #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;

  // Reference model: ph 0 = collecting, 1 = awaiting parity, 2 = word held
  int   ph = 0;
  int   n  = 0;
  logic m_left = 1'b1;
  logic m_rdy;
  logic bits[$];
  logic [SIZE-1:0] m_word;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    if (ph == 2) return 1'b0;
    if (ph == 1) return 1'b1;
    return (n > 0) || bus.left || bus.right;
  endfunction

  function automatic logic [SIZE-1:0] assemble();
    logic [SIZE-1:0] w = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (m_left) w[SIZE-1-i] = bits[i];
      else        w[i]        = bits[i];
    end
    return w;
  endfunction

  task automatic model_clear();
    ph = 0;
    n  = 0;
    bits.delete();
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    exp_t e;
    if (clr) begin
      if (ph == 2 && !bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      model_clear();
    end else if (ph == 2) begin
      if (bus.out_ready) model_clear();
    end else if (bus.sin_valid && m_rdy) begin
      if (ph == 0) begin
        if (n == 0) m_left = bus.left;
        bits.push_back(bus.sin);
        n++;
        if (n == SIZE) begin
          m_word = assemble();
`ifdef DESHIFT_PARITY_EN
          ph = 1;
`else
          e.word = m_word;
          e.perr = 1'b0;
          exp_q.push_back(e);
          ph = 2;
`endif
        end
      end else begin
        e.word = m_word;
        e.perr = (^m_word) ^ bus.sin;
        exp_q.push_back(e);
        ph = 2;
      end
    end
  endtask

  // One cycle: drive at negedge, check ready, update model at posedge
  task automatic step(input logic s, input logic sv, input logic l, input logic r,
                      input logic ordy, input logic c);
    bus.sin       = s;
    bus.sin_valid = sv;
    bus.left      = l;
    bus.right     = r;
    bus.out_ready = ordy;
    clr           = c;
    #1;
    m_rdy = model_ready();
    check("sin_ready", 32'(bus.sin_ready), 32'(m_rdy));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [SIZE-1:0] pat, input logic l, input logic r,
                           input logic ordy);
    for (int i = 0; i < SIZE; i++) step(pat[SIZE-1-i], 1'b1, l, r, ordy, 1'b0);
  endtask

  // Monitor: compare outputs against the model and scoreboard every cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("out_valid", 32'(bus.out_valid), 32'(ph == 2));
        check("cnt", 32'(bus.cnt), 32'(n));
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word: out_valid with no expected word, Q=%0h", bus.Q);
          end else begin
            check("Q", 32'(bus.Q), 32'(exp_q[0].word));
`ifdef DESHIFT_PARITY_EN
            check("parity_err", 32'(bus.parity_err), 32'(exp_q[0].perr));
`endif
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_Q", 32'(bus.Q), 32'h0);
    check("rst_cnt", 32'(bus.cnt), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_sin_ready", 32'(bus.sin_ready), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Left, right, and both-high-first-bit words with immediate consume
    send_word(8'b1011_0010, 1'b1, 1'b0, 1'b1);
`ifdef DESHIFT_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'b1011_0010, 1'b0, 1'b1, 1'b1);
`ifdef DESHIFT_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < SIZE; i++) step(1'(8'b1011_0010 >> (SIZE-1-i)), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef DESHIFT_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: word held while the source keeps offering bits
    send_word(8'b0110_1001, 1'b1, 1'b0, 1'b0);
`ifdef DESHIFT_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(8'b1100_0101, 1'b1, 1'b0, 1'b1);
`ifdef DESHIFT_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Synchronous clear after four bits, then a normal word
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_Q", 32'(bus.Q), 32'h0);
    check("clr_cnt", 32'(bus.cnt), 32'h0);
    check("clr_out_valid", 32'(bus.out_valid), 32'h0);
    send_word(8'b0011_1010, 1'b0, 1'b1, 1'b1);
`ifdef DESHIFT_PARITY_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while a word is held
    send_word(8'b1111_0000, 1'b1, 1'b0, 1'b0);
`ifdef DESHIFT_PARITY_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    model_clear();
    exp_q.delete();
    #2;
    check("arst_Q", 32'(bus.Q), 32'h0);
    check("arst_cnt", 32'(bus.cnt), 32'h0);
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_no_dir_cnt", 32'(bus.cnt), 32'h0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && (ph != 0 || exp_q.size() != 0); i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_pending", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
